frame_binarize_capture: RTL



---
 rtl/frame_binarize_capture.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/frame_binarize_capture.sv
// Binarizes a luma pixel stream into a 1-bit frame BRAM, then starts the QR decoder
// and latches its payload or a timeout. No writes occur while the decoder owns the frame.
module frame_binarize_capture #(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int DECODE_TIMEOUT = 50_000_000
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         capture_req,
    input  logic [7:0]   threshold_in,
    input  logic         pixel_valid,
    input  logic [10:0]  pixel_hcount,
    input  logic [9:0]   pixel_vcount,
    input  logic [7:0]   pixel_luma,
    output logic         bram_wr_en,
    output logic [19:0]  bram_wr_addr,
    output logic         bram_wr_data,
    output logic         start_decode,
    input  logic         finished_decode,
    input  logic [159:0] qr_in,
    output logic [159:0] qr_result,
    output logic         result_valid,
    output logic         timed_out,
    output logic         busy
);

    localparam int CNT_W = $clog2(DECODE_TIMEOUT + 1);
    localparam logic [10:0]      H_LIMIT      = 11'(WIDTH);
    localparam logic [9:0]       V_LIMIT      = 10'(HEIGHT);
    localparam logic [19:0]      MAX_ADDR     = 20'(WIDTH * HEIGHT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DECODE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_CAPTURE,
        S_START,
        S_DECODING
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_threshold;
    logic [CNT_W-1:0]   r_count;
    logic               r_wr_en;
    logic [19:0]        r_wr_addr;
    logic               r_wr_data;
    logic [159:0]       r_qr_result;
    logic               r_result_valid;
    logic               r_timed_out;

    logic               w_sof;
    logic               w_in_range;
    logic               w_last_written;
    logic               w_timeout_hit;
    logic               w_accept;
    logic               w_arm;
    logic               w_done_ok;
    logic               w_done_to;
    logic [19:0]        w_addr;

    assign w_sof          = pixel_valid && (pixel_hcount == 11'd0) && (pixel_vcount == 10'd0);
    assign w_in_range     = pixel_valid && (pixel_hcount < H_LIMIT) && (pixel_vcount < V_LIMIT);
    // The final pixel's write is on the bus this cycle; leaving CAPTURE now keeps it inside CAPTURE.
    assign w_last_written = r_wr_en && (r_wr_addr == MAX_ADDR);
    assign w_timeout_hit  = (r_count == TIMEOUT_LAST);

    generate
        if (WIDTH == 640) begin : gen_addr_shift
            assign w_addr = ({10'd0, pixel_vcount} << 9) + ({10'd0, pixel_vcount} << 7)
                          + {9'd0, pixel_hcount};
        end else begin : gen_addr_mul
            assign w_addr = 20'((32'(pixel_vcount) * WIDTH) + 32'(pixel_hcount));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_arm        = 1'b0;
        w_done_ok    = 1'b0;
        w_done_to    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (capture_req) begin
                    w_arm        = 1'b1;
                    w_state_next = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (w_sof) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_last_written) begin
                    w_state_next = S_START;
                end else begin
                    w_accept = w_in_range;
                end
            end
            S_START: begin
                w_state_next = S_DECODING;
            end
            S_DECODING: begin
                if (finished_decode) begin
                    w_done_ok    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_timeout_hit) begin
                    w_done_to    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= S_IDLE;
            r_threshold    <= 8'd0;
            r_count        <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= 20'd0;
            r_wr_data      <= 1'b0;
            r_qr_result    <= 160'd0;
            r_result_valid <= 1'b0;
            r_timed_out    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_wr_en        <= w_accept;
            r_result_valid <= w_done_ok || w_done_to;
            if (w_arm) begin
                r_threshold <= threshold_in;
            end
            if (w_accept) begin
                r_wr_addr <= w_addr;
                r_wr_data <= (pixel_luma < r_threshold);
            end
            if (r_state == S_START) begin
                r_count <= '0;
            end else if (r_state == S_DECODING) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_done_ok) begin
                r_qr_result <= qr_in;
                r_timed_out <= 1'b0;
            end else if (w_done_to) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign bram_wr_en   = r_wr_en;
    assign bram_wr_addr = r_wr_addr;
    assign bram_wr_data = r_wr_data;
    assign start_decode = (r_state == S_START);
    assign qr_result    = r_qr_result;
    assign result_valid = r_result_valid;
    assign timed_out    = r_timed_out;
    assign busy         = (r_state != S_IDLE);

endmodule
